// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and serialiser state encoding.
package mmio_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  localparam int CTRL_IE   = 0;
  localparam int CTRL_PEND = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count; pushes when full and pops
// when empty are ignored. DEPTH must be a power of two so pointers wrap freely.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; validity is tracked by the pointers
  // and count, and leaving it unreset lets it map onto plain RAM/regfile cells.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO on the data-memory bus.
// Optional interrupt (IE/PEND in CTRL, irq port) enabled by MMIO_UART_TX_IRQ_EN.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [3:0]  mem_we,
  output logic [31:0] dout,
  output logic        tx,
  output logic        busy
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic            sel, wr_en;
  logic [1:0]      reg_sel;
  logic            push_req;
  logic            fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rd_data;
  logic [CW-1:0]   fifo_count;

  tx_state_e       state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     divisor_q, divisor_d;

  logic            unused_bits;
  assign unused_bits = ^{din[31:16], addr[1:0]};

  assign sel      = (addr[31:4] == BASE_ADDR[31:4]);
  assign reg_sel  = addr[3:2];
  assign wr_en    = sel & (|mem_we);
  assign push_req = wr_en & (reg_sel == REG_TXDATA) & mem_we[0];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_req),
    .wr_data (din[7:0]),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // Overflow is judged on the registered count: a same-cycle pop does not help.
  always_comb begin
    ovf_d     = ovf_q;
    divisor_d = divisor_q;
    if (push_req && fifo_full) ovf_d = 1'b1;
    if (wr_en && reg_sel == REG_STATUS && mem_we[0] && din[STAT_OVF]) ovf_d = 1'b0;
    if (wr_en && reg_sel == REG_DIVISOR) begin
      if (mem_we[0]) divisor_d[7:0]  = din[7:0];
      if (mem_we[1]) divisor_d[15:8] = din[15:8];
    end
  end

  // Every reload samples divisor_q, so a mid-frame DIVISOR write only affects
  // bits that start after it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          cnt_d    = divisor_q;
          tx_d     = 1'b0;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d   = ST_DATA;
          cnt_d     = divisor_q;
          bit_idx_d = '0;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = divisor_q;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_rd_data;
            cnt_d    = divisor_q;
            tx_d     = 1'b0;
            state_d  = ST_START;
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
      divisor_q <= DIV_RESET;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
      divisor_q <= divisor_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != ST_IDLE) | ~fifo_empty;

`ifdef MMIO_UART_TX_IRQ_EN
  logic ie_q, ie_d, pend_q, pend_d, ctrl_wr;

  // A completion event wins over a same-cycle write-1-to-clear so it is not lost.
  always_comb begin
    ctrl_wr = wr_en & (reg_sel == REG_CTRL) & mem_we[0];
    ie_d    = ie_q;
    pend_d  = pend_q;
    if (ctrl_wr) ie_d = din[CTRL_IE];
    if (ctrl_wr && din[CTRL_PEND]) pend_d = 1'b0;
    if (state_q != ST_IDLE && state_d == ST_IDLE) pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ie_q   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      ie_q   <= ie_d;
      pend_q <= pend_d;
    end
  end

  assign irq = ie_q & pend_q;
`endif

  always_comb begin
    dout = '0;
    if (sel) begin
      unique case (reg_sel)
        REG_STATUS:  dout = {16'b0, 8'(fifo_count), 4'b0, ovf_q, busy, fifo_empty, fifo_full};
        REG_DIVISOR: dout = {16'b0, divisor_q};
`ifdef MMIO_UART_TX_IRQ_EN
        REG_CTRL:    dout = {30'b0, pend_q, ie_q};
`endif
        default:     dout = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed frames plus randomized bus
// traffic compared every cycle against a frame-level reference model.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE    = 32'h0000_1000;
  localparam int          DEPTH   = 8;
  localparam logic [15:0] DIV_RST = 16'd15;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, din;
  logic [3:0]  mem_we;
  logic [31:0] dout;
  logic        tx, busy;
`ifdef MMIO_UART_TX_IRQ_EN
  logic        irq;
`endif

  int vectors     = 0;
  int miscompares = 0;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DIV_RESET  (DIV_RST)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .din    (din),
    .mem_we (mem_we),
    .dout   (dout),
    .tx     (tx),
    .busy   (busy)
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    .irq    (irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: FIFO as a queue, frame as 10 bit slots
  bit [7:0]  mq[$];
  bit        m_ovf, m_active, m_tx, m_ie, m_pend, m_armed;
  bit [15:0] m_div;
  bit [7:0]  m_byte;
  int        m_pos, m_remain;

  function automatic bit frame_bit(input int pos, input bit [7:0] b);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos-1];
  endfunction

  function automatic logic [31:0] model_dout(input logic [31:0] a);
    logic [31:0] r;
    r = '0;
    if (a[31:4] == BASE[31:4]) begin
      case (a[3:2])
        2'd1: r = {16'b0, 8'(mq.size()), 4'b0, m_ovf, (m_active || mq.size() != 0),
                   (mq.size() == 0), (mq.size() == DEPTH)};
        2'd2: r = {16'b0, m_div};
`ifdef MMIO_UART_TX_IRQ_EN
        2'd3: r = {30'b0, m_pend, m_ie};
`endif
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic start_frame(input int d);
    m_byte   = mq.pop_front();
    m_pos    = 0;
    m_remain = d;
    m_tx     = 1'b0;
    m_active = 1'b1;
  endtask

  always @(posedge clk) begin : model
    int  old_count, old_div;
    bit  sel;
    bit  [1:0] rg;
    if (reset) begin
      mq.delete();
      m_ovf = 0; m_active = 0; m_tx = 1; m_ie = 0; m_pend = 0;
      m_div = DIV_RST; m_pos = 0; m_remain = 0; m_armed = 1;
    end else if (m_armed) begin
      old_count = mq.size();
      old_div   = int'(m_div);
      sel = (addr[31:4] == BASE[31:4]) && (mem_we != 0);
      rg  = addr[3:2];
      if (sel && rg == 2'd3 && mem_we[0]) begin
        m_ie = din[0];
        if (din[1]) m_pend = 0;
      end
      if (!m_active) begin
        if (mq.size() > 0) start_frame(old_div);
      end else if (m_remain > 0) begin
        m_remain--;
      end else if (m_pos < 9) begin
        m_pos++;
        m_tx     = frame_bit(m_pos, m_byte);
        m_remain = old_div;
      end else if (mq.size() > 0) begin
        start_frame(old_div);
      end else begin
        m_active = 0;
        m_tx     = 1;
        m_pend   = 1;
      end
      if (sel && rg == 2'd0 && mem_we[0]) begin
        if (old_count < DEPTH) mq.push_back(din[7:0]);
        else m_ovf = 1;
      end
      if (sel && rg == 2'd1 && mem_we[0] && din[3]) m_ovf = 0;
      if (sel && rg == 2'd2) begin
        if (mem_we[0]) m_div[7:0]  = din[7:0];
        if (mem_we[1]) m_div[15:8] = din[15:8];
      end
    end
  end

  always @(negedge clk) begin
    if (m_armed) begin
      check("tx", tx, m_tx);
      check("busy", busy, (m_active || mq.size() != 0));
      check("dout", dout, model_dout(addr));
`ifdef MMIO_UART_TX_IRQ_EN
      check("irq", irq, m_ie & m_pend);
`endif
    end
  end

  // ---------------- stimulus helpers (all start and end at posedge + 1)
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    addr = a; din = d; mem_we = we;
    tick(1);
    addr = '0; din = '0; mem_we = '0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    addr = a; mem_we = '0;
    #1;
    check(name, dout, exp);
    addr = '0;
  endtask

  initial begin
    logic [63:0] got, exp;
    int          a5_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    int          dc_bits [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int          dc_len  [10] = '{4, 4, 4, 4, 8, 8, 8, 8, 8, 8};
    int          idx, r, off;
    logic [31:0] a, d;
    logic [3:0]  we;

    reset = 1'b1; addr = '0; din = '0; mem_we = '0;
    tick(3);
    reset = 1'b0;

    read_check("status_reset", BASE + 32'h4, 32'h0000_0002);
    read_check("divisor_reset", BASE + 32'h8, 32'h0000_000F);
    check("tx_reset", tx, 1'b1);
    check("busy_reset", busy, 1'b0);

    // 0xA5 at divisor 3: 4 cycles per bit, LSB first
    bus_write(BASE + 32'h8, 32'd3, 4'b0011);
    bus_write(BASE, 32'hA5, 4'b0001);
    got = '0; exp = '0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      got[i] = tx;
      exp[i] = a5_bits[i/4][0];
    end
    check("a5_frame", got, exp);
    check("a5_busy_in_stop", busy, 1'b1);
    tick(1);
    check("a5_busy_after", busy, 1'b0);

    // 0x55 with DIVISOR 3->7 written mid data bit 2
    bus_write(BASE, 32'h55, 4'b0001);
    got = '0; exp = '0;
    for (int i = 0; i < 64; i++) begin
      if (i == 13) begin
        addr = BASE + 32'h8; din = 32'd7; mem_we = 4'b0011;
      end
      tick(1);
      addr = '0; din = '0; mem_we = '0;
      got[i] = tx;
    end
    idx = 0;
    for (int f = 0; f < 10; f++)
      for (int k = 0; k < dc_len[f]; k++) begin
        exp[idx] = dc_bits[f][0];
        idx++;
      end
    check("divchange_frame", got, exp);
    tick(2);

    // reset in the middle of data bit 4 with a byte still queued
    bus_write(BASE + 32'h8, 32'd3, 4'b0011);
    bus_write(BASE, 32'h3C, 4'b0001);
    bus_write(BASE, 32'hC3, 4'b0001);
    tick(21);
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("midreset_tx", tx, 1'b1);
    check("midreset_busy", busy, 1'b0);
    read_check("midreset_status", BASE + 32'h4, 32'h0000_0002);
    read_check("midreset_divisor", BASE + 32'h8, 32'h0000_000F);
    read_check("unmapped_read", BASE + 32'h10, 32'h0000_0000);

    // ten back-to-back pushes at divisor 15: one pop, eight stored, one dropped
    for (int k = 1; k <= 10; k++) bus_write(BASE, 32'(k), 4'b0001);
    read_check("overflow_status", BASE + 32'h4, 32'h0000_080D);
    bus_write(BASE + 32'h4, 32'h8, 4'b0001);
    read_check("overflow_cleared", BASE + 32'h4, 32'h0000_0805);

`ifdef MMIO_UART_TX_IRQ_EN
    reset = 1'b1; tick(1); reset = 1'b0;
    bus_write(BASE + 32'h8, 32'd1, 4'b0011);
    bus_write(BASE + 32'hC, 32'd1, 4'b0001);
    bus_write(BASE, 32'h5A, 4'b0001);
    tick(20);
    check("irq_before_idle", irq, 1'b0);
    tick(1);
    check("irq_on_idle", irq, 1'b1);
    read_check("ctrl_pending", BASE + 32'hC, 32'h3);
    bus_write(BASE + 32'hC, 32'd3, 4'b0001);
    check("irq_cleared", irq, 1'b0);
    read_check("ctrl_after_clear", BASE + 32'hC, 32'h1);
`endif

    // randomized bus traffic, short divisors, occasional reset
    reset = 1'b1; tick(1); reset = 1'b0;
    bus_write(BASE + 32'h8, 32'd0, 4'b0011);
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        reset = 1'b1; tick(1); reset = 1'b0;
      end else begin
        off = $urandom_range(0, 15);
        a   = BASE + 32'(off);
        we  = 4'($urandom_range(1, 15));
        if (r < 15) a = $urandom;
        if (r < 40) we = 4'b0000;
        if (r >= 40 && r < 70) begin
          a  = {a[31:4], 2'b00, a[1:0]};
          we = we | 4'b0001;
        end
        d = (a[3:2] == 2'd2) ? 32'($urandom_range(0, 3)) : 32'($urandom);
        addr = a; din = d; mem_we = we;
        tick(1);
      end
    end
    addr = '0; din = '0; mem_we = '0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
